// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Multicycle signed multiply/divide unit that sits beside the ALU. The CPU
// control FSM pulses MDcontrol with md_op. The unit computes one bit per
// clock and pulses done when hi/lo hold the result. Control then commits
// hi/lo into HI/LO.
//   MULT : radix-2 Booth over a 2W+1-bit product register.
//   DIV  : restoring division on operand magnitudes, then a sign fixup.
//
// Ports
//   clock      in   1      system clock; all state changes on the rising edge
//   reset      in   1      synchronous, active-low
//   MDcontrol  in   1      start request; sampled only in IDLE
//   md_op      in   1      0 = MULT (signed), 1 = DIV (signed)
//   a_in       in   WIDTH  multiplicand / dividend
//   b_in       in   WIDTH  multiplier / divisor
//   hi         out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
//   lo         out  WIDTH  MULT: product[W-1:0];  DIV: quotient
//   busy       out  1      high while an operation is in flight (RUN, DONE)
//   done       out  1      one-cycle pulse; hi/lo valid
//   Div0       out  1      one-cycle pulse with done for a DIV by zero
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MDcontrol,
  input  logic             md_op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             Div0
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  //   prod_q holds one of two layouts, depending on the operation:
  //     MULT: {A[W-1:0], Q[W-1:0], q_m1}. A is the running high half.
  //           Q is the multiplier, which shifts out as the product low half
  //           shifts in.
  //     DIV : {rem[W:0], dq[W-1:0]}. dq starts as |dividend|.
  //           Quotient bits shift into dq from the bottom.
  //   opnd_q is the multiplicand (MULT) or |divisor| (DIV).
  // ---------------------------------------------------------------------------
  state_e             state_q,  state_d;
  logic [CW-1:0]      count_q,  count_d;
  logic               op_q,     op_d;
  logic [2*WIDTH:0]   prod_q,   prod_d;
  logic [WIDTH-1:0]   opnd_q,   opnd_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q,     hi_d;
  logic [WIDTH-1:0]   lo_q,     lo_d;
  logic               done_q,   done_d;
  logic               div0_q,   div0_d;

  // ---------------------------------------------------------------------------
  // One Booth step.
  // The add/subtract is done one bit wider than A.
  // Subtracting a multiplicand of -2^(W-1) then cannot overflow before the
  // arithmetic shift.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     booth_a_ext;
  logic [WIDTH:0]     booth_m_ext;
  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH:0]   booth_next;

  always_comb begin
    booth_a_ext = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
    booth_m_ext = {opnd_q[WIDTH-1], opnd_q};
    booth_sum   = booth_a_ext;
    unique case (prod_q[1:0])
      2'b01:   booth_sum = booth_a_ext + booth_m_ext;
      2'b10:   booth_sum = booth_a_ext - booth_m_ext;
      default: booth_sum = booth_a_ext;
    endcase
    // Arithmetic shift right by one.
    // A takes sum[W:1], sum[0] enters the top of Q, and Q[0] becomes q_m1.
    booth_next = {booth_sum, prod_q[WIDTH:1]};
  end

  // ---------------------------------------------------------------------------
  // One restoring-division step on magnitudes.
  // The remainder always stays below |divisor| <= 2^(W-1).
  // The shifted partial remainder therefore fits in W+1 bits.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH:0]     div_rem_next;
  logic [2*WIDTH:0]   div_next;

  always_comb begin
    div_shift    = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_diff     = div_shift - {1'b0, opnd_q};
    div_ge       = (div_shift >= {1'b0, opnd_q});
    div_rem_next = div_ge ? div_diff : div_shift;
    div_next     = {div_rem_next, prod_q[WIDTH-2:0], div_ge};
  end

  // ---------------------------------------------------------------------------
  // Operand magnitudes at start.
  // Two's-complement negation maps -2^(W-1) onto itself.
  // Read as unsigned, that is exactly 2^(W-1).
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   quo_raw;
  logic [WIDTH-1:0]   rem_raw;

  always_comb begin
    mag_a   = a_in[WIDTH-1] ? -a_in : a_in;
    mag_b   = b_in[WIDTH-1] ? -b_in : b_in;
    quo_raw = div_next[WIDTH-1:0];
    rem_raw = div_next[2*WIDTH-1:WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first.
    // A path that leaves one unassigned would infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    prod_d    = prod_q;
    opnd_d    = opnd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div0_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (MDcontrol) begin
          op_d      = md_op;
          count_d   = '0;
          neg_quo_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
          neg_rem_d = a_in[WIDTH-1];
          if (md_op) begin
            prod_d = {{(WIDTH+1){1'b0}}, mag_a};
            opnd_d = mag_b;
            if (b_in == '0) begin
              // Divide by zero skips RUN. hi/lo keep the previous result.
              state_d = S_DONE;
              done_d  = 1'b1;
              div0_d  = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            prod_d  = {{WIDTH{1'b0}}, b_in, 1'b0};
            opnd_d  = a_in;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        prod_d  = op_q ? div_next : booth_next;
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          // Last iteration: load the result straight from the step logic.
          // That result goes onto hi/lo on this same edge.
          if (op_q) begin
            lo_d = neg_quo_q ? -quo_raw : quo_raw;
            hi_d = neg_rem_q ? -rem_raw : rem_raw;
          end else begin
            hi_d = booth_next[2*WIDTH:WIDTH+1];
            lo_d = booth_next[WIDTH:1];
          end
          count_d = '0;
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      S_DONE: begin
        // Any start request seen here is dropped, not queued.
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers (synchronous active-low reset).
  // Reset aborts any operation in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only.
    // Every flop then samples pre-edge values, whatever the statement order.
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      op_q      <= 1'b0;
      prod_q    <= '0;
      opnd_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      prod_q    <= prod_d;
      opnd_q    <= opnd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign Div0 = div0_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Self-checking bench for mult_div_unit with WIDTH = 32.
// A table of hand-computed vectors is applied in a loop. Hand-written
// sequences then cover:
//   - divide by zero
//   - a start request while busy
//   - a start request in DONE
//   - reset in the middle of an operation
// Inputs change 1 time unit after a rising edge.
// Outputs are sampled at the same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         MDcontrol;
  logic         md_op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         Div0;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .MDcontrol (MDcontrol),
    .md_op     (md_op),
    .a_in      (a_in),
    .b_in      (b_in),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .Div0      (Div0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string        name;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one operation starting from IDLE.
  // lat counts edges after the start edge until done is seen. It is 0 when
  // done is already high right after the start edge, and it is bounded.
  // Results are captured while done is high. One more edge is then taken;
  // done and busy must both have dropped by then.
  task automatic do_op(input logic op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int lat,
                       output logic [W-1:0] h, output logic [W-1:0] l,
                       output logic d0, output logic busy_at_done,
                       output logic done_after, output logic busy_after);
    MDcontrol = 1'b1;
    md_op     = op;
    a_in      = a;
    b_in      = b;
    tick();
    MDcontrol = 1'b0;
    a_in      = '0;
    b_in      = '0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    h            = hi;
    l            = lo;
    d0           = Div0;
    busy_at_done = busy;
    tick();
    done_after = done;
    busy_after = busy;
  endtask

  initial begin
    int           lat;
    logic [W-1:0] h;
    logic [W-1:0] l;
    logic         d0;
    logic         bd;
    logic         da;
    logic         ba;
    int           n_done;
    int           done_cyc;

    vecs[0]  = '{"mul_7_x_m3",        1'b0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{"mul_min_x_min",     1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[2]  = '{"mul_max_x_max",     1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[3]  = '{"mul_min_x_max",     1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 32'h8000_0000};
    vecs[4]  = '{"mul_m1_x_m1",       1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[5]  = '{"mul_x_zero",        1'b0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[6]  = '{"mul_2p16_sq",       1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[7]  = '{"div_m7_by_2",       1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[8]  = '{"div_100_by_7",      1'b1, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[9]  = '{"div_7_by_m2",       1'b1, 32'd7,        32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
    vecs[10] = '{"div_m7_by_m2",      1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3};
    vecs[11] = '{"div_min_by_m1",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[12] = '{"div_min_by_2",      1'b1, 32'h8000_0000, 32'd2,        32'h0000_0000, 32'hC000_0000};
    vecs[13] = '{"div_3_by_10",       1'b1, 32'd3,        32'd10,       32'd3,        32'd0};
    vecs[14] = '{"div_max_by_min",    1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000};

    // Reset
    reset     = 1'b0;
    MDcontrol = 1'b0;
    md_op     = 1'b0;
    a_in      = '0;
    b_in      = '0;
    tick();
    tick();
    check("reset_hi",   hi,   32'h0);
    check("reset_lo",   lo,   32'h0);
    check("reset_busy", W'(busy), 32'h0);
    check("reset_done", W'(done), 32'h0);
    check("reset_div0", W'(Div0), 32'h0);
    reset = 1'b1;
    tick();
    check("idle_hold_busy", W'(busy), 32'h0);

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, h, l, d0, bd, da, ba);
      check({vecs[i].name, "_lat"},   lat,  32'd32);
      check({vecs[i].name, "_hi"},    h,    vecs[i].exp_hi);
      check({vecs[i].name, "_lo"},    l,    vecs[i].exp_lo);
      check({vecs[i].name, "_div0"},  W'(d0), 32'h0);
      check({vecs[i].name, "_done1"}, W'(da), 32'h0);
    end
    check("hold_after_op_hi", hi, 32'h7FFF_FFFF);
    check("hold_after_op_lo", lo, 32'h0000_0000);

    // Known result, then divide by zero.
    // done and Div0 rise together right after the start edge.
    // busy is high for that one cycle, and hi/lo are unchanged.
    do_op(1'b1, 32'd100, 32'd7, lat, h, l, d0, bd, da, ba);
    do_op(1'b1, 32'd5, 32'd0, lat, h, l, d0, bd, da, ba);
    check("div0_lat",        lat,   32'd0);
    check("div0_flag",       W'(d0), 32'h1);
    check("div0_busy",       W'(bd), 32'h1);
    check("div0_hi_kept",    h,     32'd2);
    check("div0_lo_kept",    l,     32'd14);
    check("div0_done_clear", W'(da), 32'h0);
    check("div0_busy_clear", W'(ba), 32'h0);
    check("div0_flag_clear", W'(Div0), 32'h0);

    // Start request 10 cycles into a MULT is ignored.
    // Exactly one done comes, 32 edges after the start edge.
    MDcontrol = 1'b1;
    md_op     = 1'b0;
    a_in      = 32'd7;
    b_in      = 32'hFFFF_FFFD;
    tick();
    MDcontrol = 1'b0;
    n_done    = 0;
    done_cyc  = -1;
    for (int c = 1; c <= 45; c++) begin
      if (c == 10) begin
        MDcontrol = 1'b1;
        md_op     = 1'b1;
        a_in      = 32'd100;
        b_in      = 32'd7;
      end
      tick();
      if (c == 10) MDcontrol = 1'b0;
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
        check("busy_start_hi", hi, 32'hFFFF_FFFF);
        check("busy_start_lo", lo, 32'hFFFF_FFEB);
      end
    end
    check("busy_start_ndone", n_done,   32'd1);
    check("busy_start_cyc",   done_cyc, 32'd32);

    // A start request held during DONE is dropped.
    // The unit returns to IDLE and stays there.
    MDcontrol = 1'b1;
    md_op     = 1'b0;
    a_in      = 32'd2;
    b_in      = 32'd3;
    tick();
    MDcontrol = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    check("done_start_lat", lat, 32'd32);
    MDcontrol = 1'b1;
    tick();
    MDcontrol = 1'b0;
    check("done_start_busy0", W'(busy), 32'h0);
    tick();
    check("done_start_busy1", W'(busy), 32'h0);
    check("done_start_lo",    lo,       32'd6);

    // Reset 15 cycles into a DIV aborts it.
    // Outputs clear right away, and no done pulse ever comes.
    MDcontrol = 1'b1;
    md_op     = 1'b1;
    a_in      = 32'd100;
    b_in      = 32'd7;
    tick();
    MDcontrol = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_hi",   hi,       32'h0);
    check("abort_lo",   lo,       32'h0);
    check("abort_busy", W'(busy), 32'h0);
    check("abort_done", W'(done), 32'h0);
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    check("abort_no_done", n_done, 32'd0);
    do_op(1'b0, 32'd3, 32'd4, lat, h, l, d0, bd, da, ba);
    check("post_abort_lat", lat, 32'd32);
    check("post_abort_hi",  h,   32'd0);
    check("post_abort_lo",  l,   32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
